// File: rtl/mc_request_queue.sv
// In-order request queue between the trace parser and the DRAM scheduler; the head is
// released once the cycle counter reaches its timestamp. Optional stats via MC_QUEUE_STATS_EN.
module mc_request_queue #(
  parameter int ADDR_WIDTH  = 36,
  parameter int MEMOP_WIDTH = 2,
  parameter int TIME_WIDTH  = 32,
  parameter int IN_BUFF_CT  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [TIME_WIDTH-1:0]         in_time,
  input  logic [MEMOP_WIDTH-1:0]        in_op,
  input  logic [ADDR_WIDTH-1:0]         in_addr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [MEMOP_WIDTH-1:0]        out_op,
  output logic [ADDR_WIDTH-1:0]         out_addr,
  output logic [TIME_WIDTH-1:0]         out_time,
  output logic [TIME_WIDTH-1:0]         cycle_cnt,
  output logic [$clog2(IN_BUFF_CT):0]   occupancy,
  output logic                          err_op,
  output logic                          err_order
`ifdef MC_QUEUE_STATS_EN
  ,
  output logic [$clog2(IN_BUFF_CT):0]   stat_max_occ,
  output logic [31:0]                   stat_stall_cycles
`endif
);

  localparam int PTR_W = $clog2(IN_BUFF_CT);
  localparam logic [PTR_W:0] DEPTH = (PTR_W + 1)'(IN_BUFF_CT);
  localparam logic [MEMOP_WIDTH-1:0] OP_ILLEGAL = MEMOP_WIDTH'(3);

  typedef enum logic [1:0] {Q_EMPTY, Q_HOLD, Q_READY} q_state_t;

  logic [TIME_WIDTH-1:0]  mem_time [IN_BUFF_CT];
  logic [MEMOP_WIDTH-1:0] mem_op   [IN_BUFF_CT];
  logic [ADDR_WIDTH-1:0]  mem_addr [IN_BUFF_CT];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_next;
  logic [TIME_WIDTH-1:0] last_time;
  q_state_t              q_state;
  logic                  push, store, pop;

  assign in_ready  = (count < DEPTH);
  assign occupancy = count;
  assign push      = in_valid & in_ready;
  assign store     = push & (in_op != OP_ILLEGAL);
  assign pop       = out_valid & out_ready;

  // Head decode: an entry waits in HOLD until the counter catches up with its timestamp.
  always_comb begin
    q_state  = Q_EMPTY;
    out_op   = '0;
    out_addr = '0;
    out_time = '0;
    if (count != '0) begin
      out_op   = mem_op[rd_ptr];
      out_addr = mem_addr[rd_ptr];
      out_time = mem_time[rd_ptr];
      q_state  = (mem_time[rd_ptr] <= cycle_cnt) ? Q_READY : Q_HOLD;
    end
  end

  assign out_valid = (q_state == Q_READY) & ~rst;

  always_comb begin
    count_next = count;
    case ({store, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      count     <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      last_time <= '0;
      err_op    <= 1'b0;
      err_order <= 1'b0;
    end else begin
      if (cycle_cnt != '1) cycle_cnt <= cycle_cnt + 1'b1;
      count     <= count_next;
      err_op    <= push & (in_op == OP_ILLEGAL);
      err_order <= store & (in_time < last_time);
      if (store) begin
        wr_ptr    <= wr_ptr + 1'b1;
        last_time <= in_time;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (!rst && store) begin
      mem_time[wr_ptr] <= in_time;
      mem_op[wr_ptr]   <= in_op;
      mem_addr[wr_ptr] <= in_addr;
    end
  end

`ifdef MC_QUEUE_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_max_occ      <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (count_next > stat_max_occ) stat_max_occ <= count_next;
      if (in_valid && !in_ready && stat_stall_cycles != '1)
        stat_stall_cycles <= stat_stall_cycles + 1'b1;
    end
  end
`endif

endmodule

// File: doc/mc_request_queue.md
Name: mc_request_queue

Overview:
- Memory-controller front end; the receiving end of the trace-file parser's request stream.
- Accepts parsed requests {time, op, addr} over a valid/ready handshake and stores them in a 16-deep in-order queue.
- Releases the head entry to the DRAM command scheduler only once the free-running CPU-cycle counter reaches the request's timestamp.
- Flags malformed input: illegal op code, non-monotonic time.

Parameters:
- ADDR_WIDTH, 36, address field width
- MEMOP_WIDTH, 2, op-code width (0=data read, 1=data write, 2=instruction fetch, 3=illegal)
- TIME_WIDTH, 32, request timestamp and cycle-counter width
- IN_BUFF_CT, 16, queue depth (power of two, >=2)

Ports:
- clk  in  1  CPU clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  parser presents a request
- in_ready  out  1  queue can accept
- in_time  in  TIME_WIDTH  request CPU-cycle timestamp
- in_op  in  MEMOP_WIDTH  op code
- in_addr  in  ADDR_WIDTH  target address
- out_valid  out  1  head request eligible for dispatch
- out_ready  in  1  scheduler takes head
- out_op  out  MEMOP_WIDTH  head op
- out_addr  out  ADDR_WIDTH  head address
- out_time  out  TIME_WIDTH  head timestamp
- cycle_cnt  out  TIME_WIDTH  free-running CPU-cycle counter
- occupancy  out  $clog2(IN_BUFF_CT)+1  entries held
- err_op  out  1  one-cycle pulse: illegal op dropped
- err_order  out  1  one-cycle pulse: timestamp below previous accepted

Behaviour:
- Reset:
  - cycle_cnt=0, occupancy=0, pointers=0, last_time=0.
  - out_valid=0, err_op=0, err_order=0.
  - out_op/out_addr/out_time=0 while empty.
  - in_ready=1 from the first cycle after reset.
  - rst mid-operation flushes all entries; no dispatch occurs in the reset cycle.
- cycle_cnt:
  - Increments by 1 every non-reset cycle.
  - Saturates at all-ones; does not wrap.
- Push:
  - in_ready = (occupancy < IN_BUFF_CT); depends only on registered state, never on out_ready.
  - Push occurs when in_valid & in_ready.
  - When full, in_ready=0 even if a pop happens in the same cycle.
- Illegal op (in_op==3) on a handshake:
  - Handshake completes, but the entry is not stored.
  - err_op=1 on the next cycle.
  - occupancy and last_time are unchanged.
- Ordering check:
  - Legal push with in_time < last_time is stored anyway; err_order=1 on the next cycle.
  - last_time updates on every legal push.
- Output:
  - out_op/out_addr/out_time continuously reflect the head entry (registered storage, combinational read).
  - out_valid = (occupancy!=0) & (out_time <= cycle_cnt).
  - Pop occurs when out_valid & out_ready.
  - Queue is strictly in order: a not-yet-eligible head blocks younger entries.
- Latency:
  - Entry pushed in cycle N is visible at the head no earlier than N+1.
  - With an already-elapsed timestamp, out_valid rises at N+1.
- Simultaneous push and pop (not full): occupancy unchanged, both pointers advance.
- Pointers wrap modulo IN_BUFF_CT.
- Empty: out_valid=0; out_ready is ignored.
- State machine (per queue): EMPTY -> HOLD (head timestamp not reached) -> READY (out_valid=1).
  - READY -> HOLD or EMPTY on pop, depending on the next head.
  - FULL is a sub-condition of HOLD/READY that drops in_ready.

Optional Feature:
- Macro: MC_QUEUE_STATS_EN.
- Defined adds outputs:
  - stat_max_occ (occupancy width): high-water mark.
  - stat_stall_cycles (32 bits): counts cycles with in_valid & ~in_ready; saturating.
  - Both clear on rst.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then push {time=5, op=0, addr=0x01FF97000} at cycle 1 -> out_valid stays 0 until cycle_cnt=5; then out_valid=1 with out_addr=0x01FF97000 and out_op=0; pop with out_ready=1 -> occupancy=0.
- Push 16 requests with time=0 and out_ready=0 -> occupancy=16, in_ready=0. 17th in_valid held high is not accepted until one pop; it is then accepted the cycle after the pop. Entries exit in push order.
- Push time=100 then time=2, out_ready=1 -> second entry not dispatched before cycle 100 (head blocking); err_order pulses once after the second push.
- Push op=3 addr=0x123 -> err_op=1 for exactly one cycle; occupancy stays 0; out_valid stays 0.
- With 8 entries queued, assert rst for one cycle -> occupancy=0, out_valid=0, cycle_cnt=0 next cycle; a new push is accepted immediately afterwards.
- Continuous push and pop (time=0, in_valid=out_ready=1) for 40 cycles -> occupancy steady at 1; pointers wrap without loss; output sequence equals input sequence. With MC_QUEUE_STATS_EN: stat_max_occ=1, stat_stall_cycles=0.
